// File: rtl/tdc_accum_readout.sv
// tdc_accum_readout: TDC back end measuring start-to-stop intervals as coarse cycles plus thermometer fine code,
// accumulating 2^AVG_LOG2 samples and presenting the sum on a valid/ack handshake.
module tdc_accum_readout #(
    parameter int TAPS = 16,
    parameter int COARSE_W = 8,
    parameter int AVG_LOG2 = 2,
    localparam int TAP_LOG2 = $clog2(TAPS),
    localparam int FINE_W = TAP_LOG2 + 1,
    localparam int SAMPLE_W = COARSE_W + FINE_W,
    localparam int RES_W = SAMPLE_W + AVG_LOG2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [TAPS-1:0]  taps_i,
    input  logic             ack_i,
    output logic             valid_o,
    output logic [RES_W-1:0] result_o,
    output logic             ovf_o,
    output logic             busy_o
);
    typedef enum logic [1:0] {IDLE, RUN, ENC, HOLD} state_t;
    state_t state, state_nx;
    logic start_q, stop_q, start_e, stop_e, last;
    logic [COARSE_W-1:0] coarse;
    logic [TAPS-1:0] tap_q;
    logic [RES_W-1:0] acc;
    logic [AVG_LOG2-1:0] cnt;
    logic [FINE_W-1:0] fine;
    logic [SAMPLE_W-1:0] sample;

    assign start_e = start_i & ~start_q;
    assign stop_e = stop_i & ~stop_q;
    assign last = cnt == '1;
    assign busy_o = (state == RUN) || (state == ENC);

    // Popcount rather than priority encode so bubbles in the thermometer code do not cause large errors.
    always_comb begin
        fine = '0;
        for (int i = 0; i < TAPS; i++) fine = fine + FINE_W'(tap_q[i]);
        sample = (SAMPLE_W'(coarse) << TAP_LOG2) + SAMPLE_W'(fine);
    end

    always_comb begin
        state_nx = state;
        if (!ena) state_nx = IDLE;
        else case (state)
            IDLE: if (start_e) state_nx = stop_e ? ENC : RUN;
            RUN: if (stop_e || coarse == '1) state_nx = ENC;
            ENC: state_nx = last ? HOLD : IDLE;
            HOLD: if (ack_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            stop_q <= 1'b0;
        end else begin
            start_q <= start_i;
            stop_q <= stop_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coarse <= '0;
            tap_q <= '0;
            acc <= '0;
            cnt <= '0;
            valid_o <= 1'b0;
            result_o <= '0;
            ovf_o <= 1'b0;
        end else if (!ena) begin
            coarse <= '0;
            acc <= '0;
            cnt <= '0;
            valid_o <= 1'b0;
            ovf_o <= 1'b0;
        end else case (state)
            IDLE: if (start_e) begin
                coarse <= '0;
                if (stop_e) tap_q <= taps_i;
            end
            RUN: if (stop_e) tap_q <= taps_i;
            else if (coarse == '1) begin
                tap_q <= '1;
                ovf_o <= 1'b1;
            end else coarse <= coarse + 1'b1;
            ENC: begin
                acc <= acc + RES_W'(sample);
                cnt <= cnt + 1'b1;
                if (last) begin
                    result_o <= acc + RES_W'(sample);
                    valid_o <= 1'b1;
                end
            end
            HOLD: if (ack_i) begin
                valid_o <= 1'b0;
                acc <= '0;
                cnt <= '0;
                ovf_o <= 1'b0;
            end
            default: ;
        endcase
    end
endmodule

// File: doc/tdc_accum_readout.md
# tdc_accum_readout

Digital back end for the delay-line TDC: measures the interval between a start event and a stop event as a coarse clock-cycle count plus a fine thermometer-code position. It accumulates 2^AVG_LOG2 samples and presents the sum on a valid/ack handshake for readout. It sits directly downstream of the analog delay line and comparator front end, inside tt_um_13hihi31_tdc.

## Interface
- TAPS, 16: delay-line taps in the thermometer snapshot; power of two.
- COARSE_W, 8: coarse counter width.
- AVG_LOG2, 2: log2 of samples accumulated per result.
- Derived: FINE_W = clog2(TAPS)+1; SAMPLE_W = COARSE_W+FINE_W; RES_W = SAMPLE_W+AVG_LOG2. Defaults give 5, 13 and 15.

- clk  in  1  system clock (single clock domain)
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  block enable; low forces IDLE and clears state synchronously
- start_i  in  1  synchronised start level; rising edge starts a measurement
- stop_i  in  1  synchronised stop level; rising edge ends a measurement
- taps_i  in  TAPS  delay-line thermometer snapshot, already stable when the stop edge is detected
- ack_i  in  1  consumer accepts result_o
- valid_o  out  1  result_o holds a complete accumulated result
- result_o  out  RES_W  sum of 2^AVG_LOG2 samples
- ovf_o  out  1  sticky: at least one sample in this batch timed out
- busy_o  out  1  high in RUN or ENC

## Operation
- Edge detect: registered previous copies of start_i and stop_i. An edge is "current high and previous low".
- FSM states: IDLE, RUN, ENC, HOLD.
- IDLE
  - Start edge: coarse <= 0, go to RUN.
  - Start and stop edges in the same cycle: coarse <= 0, tap_q <= taps_i, go to ENC.
- RUN
  - coarse increments by 1 each cycle.
  - Stop edge: freeze coarse, tap_q <= taps_i, go to ENC.
  - Start edges are ignored.
  - coarse reaching 2^COARSE_W-1 with no stop edge (timeout): tap_q <= all ones, set ovf, go to ENC.
- ENC
  - fine = popcount(tap_q), range 0..TAPS. Popcount makes the encoding bubble tolerant.
  - sample = coarse*TAPS + fine.
  - acc <= acc + sample; cnt <= cnt + 1.
  - If cnt was 2^AVG_LOG2-1: result_o <= acc + sample, valid_o <= 1, go to HOLD. Otherwise go to IDLE.
- HOLD
  - result_o and ovf_o are stable. Start and stop edges are ignored (events are lost, not queued).
  - ack_i high: valid_o <= 0, acc <= 0, cnt <= 0, ovf <= 0, go to IDLE.
- ena low (any state): next state IDLE; acc, cnt, coarse, valid_o and ovf_o cleared; result_o holds its value. Edge-detect registers keep tracking while ena is low.
- No arithmetic wraps: the maximum sample (2^COARSE_W-1)*TAPS+TAPS fits in SAMPLE_W bits, and RES_W holds 2^AVG_LOG2 maximum samples.

## Timing
- Reset (rst_n low, asynchronous) sets:
  - state IDLE
  - valid_o 0, result_o 0, ovf_o 0, busy_o 0
  - acc 0, cnt 0, coarse 0
  - edge-detect registers 0
- Coarse resolution:
  - Start edge sampled at clock edge k; stop edge sampled at edge k+n (n ≥ 1) gives coarse = n-1.
  - Same-edge start and stop gives coarse = 0.
- Latency: stop edge at clock edge k → ENC during cycle k+1 → acc, and valid_o/result_o on the last sample, update at edge k+2.
- Timeout: the sample ends in ENC COARSE_W-dependent cycles after start: coarse = 255 with the defaults.
- Handshake:
  - valid_o stays high until ack_i is sampled high in HOLD.
  - valid_o drops on the same edge; the earliest new start is accepted on the following edge.
  - ack_i outside HOLD is ignored.
- Reset mid-RUN or mid-ENC: the partial batch is discarded and no valid_o is produced.

## Test plan
- Four measurements, each with stop 5 edges after start (coarse 4) and taps_i=16'h00FF (fine 8) → sample 72 each; valid_o after the 4th; result_o=288; ovf_o=0.
- Bubble code taps_i=16'h00FB with coarse 0, repeated 4× → fine 7; result_o=28.
- Stop never asserted → coarse saturates at 255, sample 4096; four timeouts → result_o=16384, ovf_o=1; ack clears ovf_o.
- Start and stop rising in the same cycle with taps_i=16'h0001 → sample 1. Start and stop edges during HOLD → result_o is unchanged and no extra samples are counted after ack.
- After 2 samples: drop ena, or assert rst_n low asynchronously, in RUN → acc and cnt are cleared, valid_o stays 0. The next batch of 4 samples of value 72 gives result_o=288.
